// File: rtl/ddr_app_mem_model.sv
// ddr_app_mem_model
//   Simulation stand-in for the MIG native app interface. Commands and write
//   data are decoupled through a small write-data FIFO. Writes commit with a
//   per-byte mask. Reads return after a fixed latency. Ready signals stay low
//   until a programmable calibration delay has elapsed.
//
//   Optional feature: define DDR_MODEL_STALL_EN to throttle app_rdy and
//   app_wdf_rdy pseudo-randomly from a 16-bit LFSR.
//
// Ports
//   clk, rst            model clock, asynchronous active-high reset
//   app_addr/cmd/en     command channel (000 write, 001 read, others illegal)
//   app_wdf_data/mask   write data beat, mask bit 1 = byte not written
//   app_wdf_wren/end    write data valid / last beat (must be 1)
//   app_rdy             command accepted when app_en & app_rdy
//   app_wdf_rdy         data accepted when app_wdf_wren & app_wdf_rdy
//   app_rd_data/valid   read return, READ_LATENCY cycles after accept
//   init_calib_complete calibration done, sticky until reset
//   protocol_err        sticky: beat without wdf_end, or illegal command
module ddr_app_mem_model #(
    parameter int          DATA_WIDTH   = 512,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          ADDR_LSB     = 3,
    parameter int          MEM_AW       = 10,
    parameter int          READ_LATENCY = 4,
    parameter int          WDF_DEPTH    = 4,
    parameter int          CALIB_CYCLES = 1023,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_rdy,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    init_calib_complete,
    output logic                    protocol_err
);

    localparam int MW    = DATA_WIDTH / 8;
    localparam int WORDS = 2 ** MEM_AW;
    localparam int CW    = (CALIB_CYCLES < 1) ? 1 : $clog2(CALIB_CYCLES + 1);
    localparam int PW    = $clog2(WDF_DEPTH);
    localparam int FW    = PW + 1;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    logic [CW-1:0]         calib_cnt_q;
    logic                  calib_q;
    logic                  pend_q, pend_d;
    logic [MEM_AW-1:0]     pend_idx_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [FW-1:0]         cnt_q, cnt_d;
    logic                  perr_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [WDF_DEPTH];
    logic [MW-1:0]         fifo_mask_q [WDF_DEPTH];
    // No reset on the array: contents must survive rst.
    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [READ_LATENCY-1:0] rv_q;
    logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];

    logic                  cmd_gate, wdf_gate;
    logic                  cmd_acc, wr_acc, rd_acc, bad_acc, wdf_acc;
    logic                  fifo_empty, pop, bypass, push, commit;
    logic [MEM_AW-1:0]     cmd_idx, commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [MW-1:0]         commit_mask;
    logic                  unused_addr;

    assign unused_addr = ^app_addr;

`ifdef DDR_MODEL_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (calib_q) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign cmd_gate = ~(lfsr_q[1] & lfsr_q[0]);
    assign wdf_gate = ~(lfsr_q[3] & lfsr_q[2]);
`else
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;
    assign cmd_gate    = 1'b1;
    assign wdf_gate    = 1'b1;
`endif

    assign app_rdy     = calib_q & ~pend_q & cmd_gate;
    assign app_wdf_rdy = calib_q & (cnt_q < FW'(WDF_DEPTH)) & wdf_gate;

    assign cmd_idx    = app_addr[ADDR_LSB +: MEM_AW];
    assign cmd_acc    = app_en & app_rdy;
    assign wr_acc     = cmd_acc & (app_cmd == CMD_WR);
    assign rd_acc     = cmd_acc & (app_cmd == CMD_RD);
    assign bad_acc    = cmd_acc & (app_cmd[2:1] != 2'b00);
    assign wdf_acc    = app_wdf_wren & app_wdf_rdy;
    assign fifo_empty = (cnt_q == '0);

    // A write command drains the FIFO head first; the live beat is only used
    // directly when the FIFO is empty, or to complete a pending command.
    assign pop    = wr_acc & ~fifo_empty;
    assign bypass = wdf_acc & ((wr_acc & fifo_empty) | pend_q);
    assign push   = wdf_acc & ~bypass;
    assign commit = pop | bypass;

    assign commit_idx  = pend_q ? pend_idx_q : cmd_idx;
    assign commit_data = pop ? fifo_data_q[rd_ptr_q] : app_wdf_data;
    assign commit_mask = pop ? fifo_mask_q[rd_ptr_q] : app_wdf_mask;

    always_comb begin
        pend_d = pend_q;
        if (wr_acc && fifo_empty && !wdf_acc) begin
            pend_d = 1'b1;
        end else if (pend_q && wdf_acc) begin
            pend_d = 1'b0;
        end
        cnt_d = cnt_q + FW'(push) - FW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calib_cnt_q <= CW'(CALIB_CYCLES);
            calib_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            if (!calib_q) begin
                if (calib_cnt_q == '0) begin
                    calib_q <= 1'b1;
                end else begin
                    calib_cnt_q <= calib_cnt_q - 1'b1;
                end
            end
            pend_q <= pend_d;
            if (wr_acc && fifo_empty && !wdf_acc) begin
                pend_idx_q <= cmd_idx;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            cnt_q  <= cnt_d;
            perr_q <= perr_q | bad_acc | (wdf_acc & ~app_wdf_end);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= app_wdf_data;
            fifo_mask_q[wr_ptr_q] <= app_wdf_mask;
        end
        if (commit) begin
            for (int i = 0; i < MW; i++) begin
                if (!commit_mask[i]) begin
                    mem_q[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // Read data is captured at accept and then only shifted, so later writes
    // to the same word cannot leak into an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rv_q[0]      <= rd_acc;
            rd_pipe_q[0] <= rd_acc ? mem_q[cmd_idx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rv_q[i]      <= rv_q[i-1];
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign app_rd_data         = rd_pipe_q[READ_LATENCY-1];
    assign app_rd_data_valid   = rv_q[READ_LATENCY-1];
    assign init_calib_complete = calib_q;
    assign protocol_err        = perr_q;

endmodule

// File: tb/tb_ddr_app_mem_model.sv
// Directed bench for ddr_app_mem_model with CALIB_CYCLES = 16.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
module tb_ddr_app_mem_model;

    localparam int DW = 512;
    localparam int AW = 16;
    localparam int MW = DW / 8;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          init_calib_complete;
    logic          protocol_err;

    always #5 clk = ~clk;

    ddr_app_mem_model #(.CALIB_CYCLES(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .protocol_err        (protocol_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    logic [DW-1:0] rd_q [$];
    int            rd_cyc_q [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            rd_q.push_back(app_rd_data);
            rd_cyc_q.push_back(cyc_n);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        app_addr     = '0;
        app_cmd      = '0;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + i;
        return {16{w}};
    endfunction

    // Entered and left just after a rising edge; acc = accept cycle index.
    task automatic issue_cmd(input logic [2:0] c, input logic [AW-1:0] a, input bit wd,
                             input logic [DW-1:0] d, input logic [MW-1:0] m, output int acc);
        app_en       = 1'b1;
        app_cmd      = c;
        app_addr     = a;
        app_wdf_wren = wd;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end  = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (app_rdy) break;
            step();
        end
        check("cmd_rdy", app_rdy, 1'b1);
        acc = cyc_n;
        step();
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
    endtask

    task automatic get_rd(input string tag, input int acc, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        int            c;
        for (int t = 0; t < 64 && rd_q.size() == 0; t++) step();
        check({tag, "_valid"}, DW'(rd_q.size() > 0), 1'b1);
        if (rd_q.size() > 0) begin
            d = rd_q.pop_front();
            c = rd_cyc_q.pop_front();
            check({tag, "_data"}, d, exp);
            check({tag, "_lat"}, DW'(c - acc), DW'(4));
        end
    endtask

    initial begin
        int acc;
        int accs [4];
        logic [DW-1:0] p5a;
        logic [DW-1:0] pnew;
        logic [MW-1:0] m_fe;
        p5a  = {64{8'h5A}};
        pnew = {64{8'hA7}};
        m_fe = '1;
        m_fe[0] = 1'b0;

        idle();
        repeat (3) step();
        @(negedge clk);
        check("rst_rdy",   app_rdy, 1'b0);
        check("rst_wrdy",  app_wdf_rdy, 1'b0);
        check("rst_valid", app_rd_data_valid, 1'b0);
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_perr",  protocol_err, 1'b0);
        step();
        rst = 1'b0;

        // calibration: 16 edges after release still low, edge 17 sets it
        repeat (16) step();
        @(negedge clk);
        check("calib_16", init_calib_complete, 1'b0);
        check("rdy_16",   app_rdy, 1'b0);
        check("wrdy_16",  app_wdf_rdy, 1'b0);
        step();
        @(negedge clk);
        check("calib_17", init_calib_complete, 1'b1);
        check("rdy_17",   app_rdy, 1'b1);
        check("wrdy_17",  app_wdf_rdy, 1'b1);
        step();

        // write with same-cycle beat, read next cycle
        issue_cmd(WR, 16'h0040, 1'b1, p5a, '0, acc);
        issue_cmd(RD, 16'h0040, 1'b0, '0, '0, acc);
        get_rd("wr_rd", acc, p5a);

        // byte mask: only byte 0 written over a zero word
        issue_cmd(WR, 16'h0080, 1'b1, '0, '0, acc);
        issue_cmd(WR, 16'h0080, 1'b1, '1, m_fe, acc);
        issue_cmd(RD, 16'h0080, 1'b0, '0, '0, acc);
        get_rd("mask", acc, DW'(8'hFF));

        // data-first: fill the FIFO, then commands pop it in order
        for (int i = 0; i < 4; i++) begin
            app_wdf_wren = 1'b1;
            app_wdf_data = pat(i);
            app_wdf_mask = '0;
            @(negedge clk);
            check("wrdy_fill", app_wdf_rdy, 1'b1);
            step();
        end
        app_wdf_wren = 1'b0;
        @(negedge clk);
        check("wrdy_full", app_wdf_rdy, 1'b0);
        step();
        for (int i = 0; i < 4; i++) issue_cmd(WR, AW'(i << 3), 1'b0, '0, '0, acc);
        @(negedge clk);
        check("wrdy_drain", app_wdf_rdy, 1'b1);
        step();
        for (int i = 0; i < 4; i++) issue_cmd(RD, AW'(i << 3), 1'b0, '0, '0, accs[i]);
        for (int i = 0; i < 4; i++) get_rd($sformatf("dfirst%0d", i), accs[i], pat(i));

        // cmd-first: write to 0x8 pends until the beat, read queued behind
        issue_cmd(WR, 16'h0008, 1'b0, '0, '0, acc);
        app_en   = 1'b1;
        app_cmd  = RD;
        app_addr = 16'h0008;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("pend_rdy", app_rdy, 1'b0);
            step();
        end
        app_wdf_wren = 1'b1;
        app_wdf_data = pnew;
        app_wdf_mask = '0;
        @(negedge clk);
        check("pend_rdy5", app_rdy, 1'b0);
        step();
        app_wdf_wren = 1'b0;
        @(negedge clk);
        check("pend_clr", app_rdy, 1'b1);
        acc = cyc_n;
        step();
        app_en = 1'b0;
        get_rd("cfirst", acc, pnew);

        // illegal command: accepted, sets protocol_err, word 0 unchanged
        @(negedge clk);
        check("perr_pre", protocol_err, 1'b0);
        step();
        issue_cmd(3'b011, 16'h0000, 1'b0, '0, '0, acc);
        @(negedge clk);
        check("perr_cmd", protocol_err, 1'b1);
        step();
        issue_cmd(RD, 16'h0000, 1'b0, '0, '0, acc);
        get_rd("illegal_noeff", acc, pat(0));

        // reset two cycles after a read accept drops it; memory survives
        rd_q.delete();
        rd_cyc_q.delete();
        issue_cmd(RD, 16'h0040, 1'b0, '0, '0, acc);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check("rst_drop", DW'(rd_q.size()), '0);
        check("rst_perr_clr", protocol_err, 1'b0);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (init_calib_complete) break;
            step();
        end
        check("recal", init_calib_complete, 1'b1);
        step();
        issue_cmd(RD, 16'h0040, 1'b0, '0, '0, acc);
        get_rd("mem_kept", acc, p5a);

        // data beat without wdf_end
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        step();
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b1;
        @(negedge clk);
        check("perr_end", protocol_err, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
